mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type, defaults and requester indices for mem_port_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int MEM_W_DEF       = 32;
    localparam int NUM_REQ_DEF     = 3;
    localparam int TIMEOUT_CYC_DEF = 1024;

    localparam int REQ_IBEX_INSTR = 0;
    localparam int REQ_IBEX_DATA  = 1;
    localparam int REQ_VICUNA     = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin winner selection starting at a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int unsigned      w_sum;
    logic [IDX_W-1:0] w_pos;

    // Scan lowest priority first so the highest-priority hit is the last write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_sum = 0;
        w_pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = 32'(ptr) + 32'(k);
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_pos = IDX_W'(w_sum);
            if (req[w_pos]) begin
                valid = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding round-robin arbiter from core requesters to the mmu port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_W       = MEM_W_DEF,
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*32-1:0]      addr_i,
    input  logic [NUM_REQ-1:0]         we_i,
    input  logic [NUM_REQ*MEM_W/8-1:0] be_i,
    input  logic [NUM_REQ*MEM_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [NUM_REQ-1:0]         err_o,
    output logic [MEM_W-1:0]           rdata_o,
    output logic                       mem_req_o,
    output logic [31:0]                mem_addr_o,
    output logic                       mem_we_o,
    output logic [MEM_W/8-1:0]         mem_be_o,
    output logic [MEM_W-1:0]           mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic                       mem_err_i,
    input  logic [MEM_W-1:0]           mem_rdata_i,
    output logic                       busy_o
);

    localparam int BE_W  = MEM_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic               r_we;
    logic [BE_W-1:0]    r_be;
    logic [MEM_W-1:0]   r_wdata;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [NUM_REQ-1:0] r_err;
    logic [MEM_W-1:0]   r_rdata;

    logic               w_win_valid;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_resp;
    logic               w_finish;
    logic               w_timeout;
    logic [31:0]        w_sel_addr;
    logic               w_sel_we;
    logic [BE_W-1:0]    w_sel_be;
    logic [MEM_W-1:0]   w_sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (req_i),
        .ptr   (r_rr_ptr),
        .valid (w_win_valid),
        .idx   (w_win_idx)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_sel_addr  = addr_i[32*i +: 32];
                w_sel_we    = we_i[i];
                w_sel_be    = be_i[BE_W*i +: BE_W];
                w_sel_wdata = wdata_i[MEM_W*i +: MEM_W];
            end
        end
    end

    assign w_resp     = mem_rvalid_i | mem_err_i;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_ptr_nxt  = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A response on the last wait cycle still wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_resp) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_resp) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_timeout   = 1'b1;
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            r_err    <= '0;
            if (r_state == ST_IDLE && w_win_valid) begin
                r_owner <= w_win_idx;
                r_addr  <= w_sel_addr;
                r_we    <= w_sel_we;
                r_be    <= w_sel_be;
                r_wdata <= w_sel_wdata;
                r_cnt   <= '0;
            end
            if (r_state == ST_WAIT && !w_finish) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_rr_ptr <= w_ptr_nxt;
                if (w_timeout || mem_err_i) begin
                    r_err <= w_owner_oh;
                end else begin
                    r_rvalid <= w_owner_oh;
                    r_rdata  <= mem_rdata_i;
                end
            end
        end
    end

    assign gnt_o       = (r_state == ST_ISSUE) ? w_owner_oh : '0;
    assign mem_req_o   = (r_state == ST_ISSUE);
    assign busy_o      = (r_state != ST_IDLE);
    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;
    assign rvalid_o    = r_rvalid;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;

endmodule
